fpadd_sched: RTL and testbench

Round-robin scheduler that shares one fixed-latency pipelined floating-point adder among NREQ requesters. Each requester issues operand pairs over a valid/ready handshake. The scheduler registers the winning operands into the adder, tracks each operation's owner through a tag shift register matched to the adder latency, and returns every sum on that requester's response handshake. It sits between the client blocks and the adder datapath. It performs no arithmetic itself.

---
 rtl/fpadd_sched.sv | 179 +++++++++++++++++
 tb/tb_fpadd_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined FP adder among NREQ requesters.
// Owner tags ride a shift register aligned to the adder so each sum returns to its issuer.
module fpadd_sched #(
    parameter int NREQ = 4,
    parameter int N    = 32,
    parameter int LAT  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [NREQ*N-1:0]         rsp_sum,
    output logic [N-1:0]              add_a,
    output logic [N-1:0]              add_b,
    output logic                      add_vld,
    input  logic [N-1:0]              add_sum,
    output logic [$clog2(NREQ+1)-1:0] inflight,
    output logic                      busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(NREQ + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StInfl = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]      state_q [NREQ];
    logic [1:0]      state_d [NREQ];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] elig;
    logic [PW:0]     cand;
    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;

    logic [N-1:0]    add_a_q, add_b_q;
    // Stage 0 is the issue register (drives add_vld); stage LAT lines up with add_sum.
    logic [LAT:0]    tvld_q;
    logic [PW-1:0]   ttag_q [LAT+1];
    logic            ret_vld;
    logic [PW-1:0]   ret_tag;

    logic [NREQ*N-1:0] rsp_sum_q;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     rsp_cnt;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && (state_q[i] == StIdle);
        end
    end

    // First eligible requester at or after ptr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!gnt_any && elig[cand[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign ret_vld = tvld_q[LAT];
    assign ret_tag = ttag_q[LAT];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                StIdle: if (gnt_any && gnt_idx == PW'(i)) state_d[i] = StInfl;
                StInfl: if (ret_vld && ret_tag == PW'(i)) state_d[i] = StDone;
                StDone: if (rsp_ready[i]) state_d[i] = StIdle;
                default: state_d[i] = StIdle;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = (state_q[i] == StDone);
        end
    end

    // Several requesters may accept responses in the same cycle.
    always_comb begin
        rsp_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_cnt = rsp_cnt + CW'(rsp_valid[i] & rsp_ready[i]);
        end
    end

    assign inflight_d = inflight_q + CW'(gnt_any) - rsp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= StIdle;
            end
            ptr_q      <= '0;
            inflight_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= state_d[i];
            end
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_q <= '0;
            add_b_q <= '0;
        end else if (gnt_any) begin
            add_a_q <= req_a[gnt_idx*N +: N];
            add_b_q <= req_b[gnt_idx*N +: N];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvld_q <= '0;
            for (int k = 0; k <= LAT; k++) begin
                ttag_q[k] <= '0;
            end
        end else begin
            tvld_q    <= {tvld_q[LAT-1:0], gnt_any};
            ttag_q[0] <= gnt_idx;
            for (int k = 1; k <= LAT; k++) begin
                ttag_q[k] <= ttag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sum_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (ret_vld && ret_tag == PW'(i)) begin
                    rsp_sum_q[i*N +: N] <= add_sum;
                end
            end
        end
    end

    assign add_a    = add_a_q;
    assign add_b    = add_b_q;
    assign add_vld  = tvld_q[0];
    assign rsp_sum  = rsp_sum_q;
    assign inflight = inflight_q;
    assign busy     = (inflight_q != '0);

endmodule

// File: tb/tb_fpadd_sched.sv
// Directed bench for fpadd_sched with a behavioural LAT-deep exact single-precision adder.
module tb_fpadd_sched;

    localparam int NREQ = 4;
    localparam int N    = 32;
    localparam int LAT  = 3;

    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;
    localparam logic [31:0] F5 = 32'h40A0_0000;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [NREQ*N-1:0] rsp_sum;
    logic [N-1:0]      add_a;
    logic [N-1:0]      add_b;
    logic              add_vld;
    logic [N-1:0]      add_sum;
    logic [2:0]        inflight;
    logic              busy;

    int vectors;
    int miscompares;

    fpadd_sched #(.NREQ(NREQ), .N(N), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_vld   (add_vld),
        .add_sum   (add_sum),
        .inflight  (inflight),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    logic [31:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= r2sp(sp2r(add_a) + sp2r(add_b));
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
    end
    assign add_sum = apipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic md();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  seen;
        logic [31:0] sums [4];
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        rsp_ready   = '0;
        req_a       = '0;
        req_b       = '0;

        // Reset values
        md();
        chk("rst_add_vld", add_vld, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_busy", busy, 0);
        nc();
        rst_n = 1'b1;

        // Single request 1.0 + 2.0
        set_op(0, F1, F2);
        req_valid = 4'b0001;
        md();
        chk("single_ready", req_ready, 4'b0001);
        nc();
        req_valid = '0;
        md();
        chk("single_add_vld", add_vld, 1);
        chk("single_add_a", add_a, F1);
        chk("single_add_b", add_b, F2);
        chk("single_inflight", inflight, 1);
        chk("single_busy", busy, 1);
        repeat (3) nc();
        md();
        chk("single_early", rsp_valid, 0);
        nc();
        md();
        chk("single_rsp_valid", rsp_valid, 4'b0001);
        chk("single_sum", rsp_sum[0 +: N], F3);
        nc();
        rsp_ready = 4'b0001;
        md();
        chk("single_hold", rsp_valid, 4'b0001);
        nc();
        rsp_ready = '0;
        md();
        chk("single_freed", rsp_valid, 0);
        chk("single_inflight0", inflight, 0);
        chk("single_busy0", busy, 0);
        nc();

        // Reset mid-operation: ptr=1, so grants go 1,2,0
        set_op(0, F1, F1);
        set_op(1, F2, F2);
        set_op(2, F1, F2);
        req_valid = 4'b0111;
        md();
        chk("flush_gnt1", req_ready, 4'b0010);
        nc();
        md();
        chk("flush_gnt2", req_ready, 4'b0100);
        nc();
        md();
        chk("flush_gnt0", req_ready, 4'b0001);
        nc();
        req_valid = '0;
        md();
        chk("flush_inflight3", inflight, 3);
        nc();
        rst_n = 1'b0;
        #1;
        chk("flush_inflight", inflight, 0);
        chk("flush_busy", busy, 0);
        chk("flush_add_vld", add_vld, 0);
        chk("flush_add_a", add_a, 0);
        chk("flush_rsp_valid", rsp_valid, 0);
        nc();
        nc();
        rst_n = 1'b1;
        seen = '0;
        repeat (8) begin
            md();
            seen = seen | rsp_valid;
            nc();
        end
        chk("flush_never_valid", seen, 0);
        chk("flush_rsp_sum", rsp_sum, 0);
        chk("flush_inflight_after", inflight, 0);

        // All four at once with ptr=0, then full occupancy
        set_op(0, F1, F1);
        set_op(1, F2, F1);
        set_op(2, F3, F1);
        set_op(3, F4, F1);
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            md();
            chk("all_grant", req_ready, 64'(4'b0001 << k));
            if (k > 0) chk("all_add_vld", add_vld, 1);
            nc();
        end
        md();
        chk("all_add_vld_last", add_vld, 1);
        chk("all_add_a_last", add_a, F4);
        chk("full_inflight", inflight, 4);
        chk("full_busy", busy, 1);
        chk("full_no_ready", req_ready, 0);
        nc();
        for (int k = 0; k < 4; k++) begin
            md();
            chk("all_rsp_order", rsp_valid, 64'((5'b00010 << k) - 5'd1));
            nc();
        end
        sums[0] = F2;
        sums[1] = F3;
        sums[2] = F4;
        sums[3] = F5;
        for (int i = 0; i < 4; i++) begin
            chk("all_sum", rsp_sum[i*N +: N], sums[i]);
        end
        rsp_ready = 4'b0001;
        md();
        chk("full_still_no_ready", req_ready, 0);
        nc();
        rsp_ready = '0;
        md();
        chk("full_regrant0", req_ready, 4'b0001);
        chk("full_inflight3", inflight, 3);
        req_valid = '0;
        rsp_ready = 4'b1110;
        nc();
        rsp_ready = '0;
        md();
        chk("full_drain_valid", rsp_valid, 0);
        chk("full_drain_inflight", inflight, 0);
        nc();

        // Fairness: grant 2 moves ptr to 3, so 3 beats 0
        set_op(2, F1, F1);
        req_valid = 4'b0100;
        md();
        chk("fair_gnt2", req_ready, 4'b0100);
        nc();
        set_op(3, F2, F2);
        set_op(0, F1, F2);
        req_valid = 4'b1001;
        md();
        chk("fair_gnt3_first", req_ready, 4'b1000);
        nc();
        req_valid = 4'b0001;
        md();
        chk("fair_gnt0_next", req_ready, 4'b0001);
        nc();
        req_valid = '0;
        repeat (2) nc();
        md();
        chk("fair_rsp2", rsp_valid, 4'b0100);
        nc();
        md();
        chk("fair_rsp3", rsp_valid, 4'b1100);
        nc();
        md();
        chk("fair_rsp0", rsp_valid, 4'b1101);
        chk("fair_sum2", rsp_sum[2*N +: N], F2);
        chk("fair_sum3", rsp_sum[3*N +: N], F4);
        chk("fair_sum0", rsp_sum[0 +: N], F3);
        rsp_ready = 4'b1111;
        nc();
        rsp_ready = '0;
        md();
        chk("fair_drained", rsp_valid, 0);
        nc();

        // Back-pressure on requester 1; ptr=1 picks 1 out of all four
        set_op(1, F1, F1);
        set_op(2, F2, F2);
        req_valid = 4'b1111;
        rsp_ready = 4'b0101;
        md();
        chk("bp_ptr1", req_ready, 4'b0010);
        nc();
        req_valid = 4'b0111;
        md();
        chk("bp_gnt2", req_ready, 4'b0100);
        nc();
        req_valid = 4'b0011;
        md();
        chk("bp_gnt0", req_ready, 4'b0001);
        nc();
        req_valid = 4'b0010;
        md();
        chk("bp_none", req_ready, 0);
        nc();
        nc();
        md();
        chk("bp_rsp1", rsp_valid, 4'b0010);
        chk("bp_sum1", rsp_sum[1*N +: N], F2);
        nc();
        md();
        chk("bp_rsp12", rsp_valid, 4'b0110);
        chk("bp_sum2", rsp_sum[2*N +: N], F4);
        nc();
        md();
        chk("bp_rsp10", rsp_valid, 4'b0011);
        chk("bp_sum0", rsp_sum[0 +: N], F3);
        nc();
        rsp_ready = 4'b0111;
        md();
        chk("bp_held_valid", rsp_valid, 4'b0010);
        chk("bp_no_ready", req_ready, 0);
        chk("bp_sum1_stable", rsp_sum[1*N +: N], F2);
        chk("bp_inflight1", inflight, 1);
        nc();
        rsp_ready = 4'b0101;
        md();
        chk("bp_regrant1", req_ready, 4'b0010);
        chk("bp_freed", rsp_valid, 0);
        chk("bp_inflight0", inflight, 0);
        nc();
        req_valid = '0;
        md();
        chk("bp_reissue_vld", add_vld, 1);
        chk("bp_reissue_inflight", inflight, 1);
        rsp_ready = 4'b1111;
        repeat (6) nc();
        md();
        chk("bp_drain_valid", rsp_valid, 0);
        chk("bp_drain_inflight", inflight, 0);
        nc();

        // Issue on 2 in the same cycle as accept on 0
        rsp_ready = '0;
        set_op(0, F3, F1);
        req_valid = 4'b0001;
        md();
        chk("cnt_gnt0", req_ready, 4'b0001);
        nc();
        req_valid = '0;
        repeat (4) nc();
        set_op(2, F1, F1);
        req_valid = 4'b0100;
        rsp_ready = 4'b0001;
        md();
        chk("cnt_rsp0", rsp_valid, 4'b0001);
        chk("cnt_sum0", rsp_sum[0 +: N], F4);
        chk("cnt_gnt2", req_ready, 4'b0100);
        chk("cnt_inflight_before", inflight, 1);
        nc();
        req_valid = '0;
        rsp_ready = '0;
        md();
        chk("cnt_inflight_same", inflight, 1);
        chk("cnt_rsp_cleared", rsp_valid, 0);
        chk("cnt_add_vld", add_vld, 1);
        chk("cnt_add_a", add_a, F1);
        rsp_ready = 4'b1111;
        repeat (6) nc();
        md();
        chk("cnt_sum2", rsp_sum[2*N +: N], F2);
        chk("cnt_final_inflight", inflight, 0);
        chk("cnt_final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
